// File: rtl/indicator_shift_out_pkg.sv
// Shared types and sizing helpers for the indicator bar shift-out block.
// Optional build macro INDICATOR_SHIFT_OUT_SKIP_UNCHANGED_EN is consumed by indicator_shift_out.
package indicator_shift_out_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT_LO = 2'd1,
      SHIFT_HI = 2'd2,
      LATCH    = 2'd3
   } state_t;

   // Bits needed to hold the values 0..n (counters compare against a terminal count).
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   // Cycles from the accepting edge until i_ready is driven high again.
   function automatic int unsigned frame_len(input int unsigned n_bits,
                                             input int unsigned div);
      return 2 * div * n_bits + div;
   endfunction

endpackage

// File: rtl/indicator_shift_out_phase.sv
// clk_div phase counter: while run is high it emits a one-cycle tick every clk_div cycles.
// Idle (run low) holds the count at zero so every state starts on a fresh phase.
module indicator_shift_out_phase
   import indicator_shift_out_pkg::*;
#(
   parameter int unsigned clk_div = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic tick
);

   localparam int unsigned PW = cnt_w(clk_div);

   logic [PW-1:0] cnt;

   assign tick = run && (cnt == PW'(clk_div - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (!run || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + PW'(1);
      end
   end

endmodule

// File: rtl/indicator_shift_out.sv
// Serialises accepted indicator arrays onto a daisy-chained 74HC595-style LED driver.
// Build macro INDICATOR_SHIFT_OUT_SKIP_UNCHANGED_EN drops arrays equal to the last latched frame.
module indicator_shift_out
   import indicator_shift_out_pkg::*;
#(
   parameter int unsigned width     = 32,
   parameter int unsigned clk_div   = 4,
   parameter bit          msb_first = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [width-1:0] i_array,
   output logic             o_sclk,
   output logic             o_sdata,
   output logic             o_latch,
   output logic             o_busy
);

   localparam int unsigned BW = cnt_w(width);

   state_t           state, state_nxt;
   logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
   logic [width-1:0] sh_reg, sh_nxt;
   logic             sclk_nxt, sdata_nxt, latch_nxt, ready_nxt, busy_nxt;
   logic             tick;
   logic             accept;
   logic             skip_frame;

   // The shift register rotates rather than shifts, so after width steps it
   // holds the original frame again.
   function automatic logic [width-1:0] rot(input logic [width-1:0] v);
      if (msb_first) return (v << 1) | (v >> (width - 1));
      else           return (v >> 1) | (v << (width - 1));
   endfunction

   function automatic logic head(input logic [width-1:0] v);
      return msb_first ? v[width-1] : v[0];
   endfunction

   assign accept = i_valid && i_ready;

   indicator_shift_out_phase #(
      .clk_div (clk_div)
   ) u_phase (
      .clk   (clk),
      .reset (reset),
      .run   (state != IDLE),
      .tick  (tick)
   );

`ifdef INDICATOR_SHIFT_OUT_SKIP_UNCHANGED_EN
   logic [width-1:0] last_shifted;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_shifted <= '0;
      end else if (state == LATCH && tick) begin
         last_shifted <= sh_reg;
      end
   end

   assign skip_frame = (i_array == last_shifted);
`else
   assign skip_frame = 1'b0;
`endif

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      sh_nxt      = sh_reg;
      sclk_nxt    = o_sclk;
      sdata_nxt   = o_sdata;
      latch_nxt   = o_latch;
      ready_nxt   = i_ready;
      busy_nxt    = o_busy;
      case (state)
         IDLE: begin
            ready_nxt   = 1'b1;
            busy_nxt    = 1'b0;
            sclk_nxt    = 1'b0;
            sdata_nxt   = 1'b0;
            latch_nxt   = 1'b0;
            bit_cnt_nxt = '0;
            if (accept && !skip_frame) begin
               sh_nxt    = i_array;
               sdata_nxt = head(i_array);
               ready_nxt = 1'b0;
               busy_nxt  = 1'b1;
               state_nxt = SHIFT_LO;
            end
         end
         SHIFT_LO: begin
            if (tick) begin
               sclk_nxt  = 1'b1;
               state_nxt = SHIFT_HI;
            end
         end
         SHIFT_HI: begin
            if (tick) begin
               sclk_nxt = 1'b0;
               sh_nxt   = rot(sh_reg);
               if (bit_cnt == BW'(width - 1)) begin
                  bit_cnt_nxt = '0;
                  sdata_nxt   = 1'b0;
                  latch_nxt   = 1'b1;
                  state_nxt   = LATCH;
               end else begin
                  bit_cnt_nxt = bit_cnt + BW'(1);
                  sdata_nxt   = head(rot(sh_reg));
                  state_nxt   = SHIFT_LO;
               end
            end
         end
         LATCH: begin
            if (tick) begin
               latch_nxt = 1'b0;
               ready_nxt = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         bit_cnt <= '0;
         o_sclk  <= 1'b0;
         o_sdata <= 1'b0;
         o_latch <= 1'b0;
         i_ready <= 1'b0;
         o_busy  <= 1'b0;
      end else begin
         state   <= state_nxt;
         bit_cnt <= bit_cnt_nxt;
         o_sclk  <= sclk_nxt;
         o_sdata <= sdata_nxt;
         o_latch <= latch_nxt;
         i_ready <= ready_nxt;
         o_busy  <= busy_nxt;
      end
   end

   // Frame data carries no reset; it is always loaded before it is shifted.
   always_ff @(posedge clk) begin
      sh_reg <= sh_nxt;
   end

endmodule

// File: tb/tb_indicator_shift_out.sv
// Scoreboard bench for indicator_shift_out: three instances (8/2 msb, 8/2 lsb, 32/1 msb).
// Honours INDICATOR_SHIFT_OUT_SKIP_UNCHANGED_EN for the duplicate-frame expectation.
module tb_indicator_shift_out;

   typedef struct packed {
      logic [31:0] seq;
      int          nbits;
      int          lat_cyc;
      int          busy_cyc;
      int          gap;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [2:0]  valid;
   logic [2:0]  ready, sclk, sdata, latch, busy;
   logic [7:0]  arr_a, arr_b;
   logic [31:0] arr_c;

   int n_checks = 0;
   int n_fail   = 0;

   exp_t exp_q [3][$];

   indicator_shift_out #(.width(8), .clk_div(2), .msb_first(1'b1)) dut_a (
      .clk(clk), .reset(rst_n), .i_valid(valid[0]), .i_ready(ready[0]), .i_array(arr_a),
      .o_sclk(sclk[0]), .o_sdata(sdata[0]), .o_latch(latch[0]), .o_busy(busy[0]));

   indicator_shift_out #(.width(8), .clk_div(2), .msb_first(1'b0)) dut_b (
      .clk(clk), .reset(rst_n), .i_valid(valid[1]), .i_ready(ready[1]), .i_array(arr_b),
      .o_sclk(sclk[1]), .o_sdata(sdata[1]), .o_latch(latch[1]), .o_busy(busy[1]));

   indicator_shift_out #(.width(32), .clk_div(1), .msb_first(1'b1)) dut_c (
      .clk(clk), .reset(rst_n), .i_valid(valid[2]), .i_ready(ready[2]), .i_array(arr_c),
      .o_sclk(sclk[2]), .o_sdata(sdata[2]), .o_latch(latch[2]), .o_busy(busy[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int ch, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL ch%0d %s: actual 0x%0h required 0x%0h", ch, nm, act, exp);
      end
   endtask

   task automatic push(input int ch, input logic [31:0] seq, input int nbits,
                       input int lat_cyc, input int busy_cyc, input int gap);
      exp_t e;
      e.seq = seq; e.nbits = nbits; e.lat_cyc = lat_cyc; e.busy_cyc = busy_cyc; e.gap = gap;
      exp_q[ch].push_back(e);
   endtask

   task automatic drive(input int ch, input logic [31:0] d);
      case (ch)
         0:       arr_a = d[7:0];
         1:       arr_b = d[7:0];
         default: arr_c = d;
      endcase
   endtask

   // Present an array and return 1 ns after the edge that accepts it.
   task automatic send(input int ch, input logic [31:0] d, input bit hold);
      int n;
      n = 0;
      @(negedge clk);
      valid[ch] = 1'b1;
      drive(ch, d);
      while (!ready[ch] && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!ready[ch]) begin
         check("accept_timeout", ch, 32'd0, 32'd1);
         valid[ch] = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         if (!hold) valid[ch] = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || exp_q[2].size() != 0 ||
              busy != 3'b000) && n < 500) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
   endtask

   // Monitor: collects bits at sclk rising edges and scores each frame at its latch pulse.
   int          cyc = 0;
   logic [31:0] bits [3];
   int          nrise [3];
   int          lat_cnt [3];
   int          busy_cnt [3];
   int          last_lat [3];
   logic [2:0]  p_sclk, p_latch, p_busy;
   exp_t        cur [3];

   initial begin
      p_sclk = '0; p_latch = '0; p_busy = '0;
      for (int ch = 0; ch < 3; ch++) begin
         bits[ch] = '0; nrise[ch] = 0; lat_cnt[ch] = 0; busy_cnt[ch] = 0; last_lat[ch] = 0;
         cur[ch] = '0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         for (int ch = 0; ch < 3; ch++) begin
            if (!rst_n) begin
               bits[ch] = '0; nrise[ch] = 0; lat_cnt[ch] = 0; busy_cnt[ch] = 0;
               p_sclk[ch] = 1'b0; p_latch[ch] = 1'b0; p_busy[ch] = 1'b0;
            end else begin
               if (sclk[ch] && !p_sclk[ch]) begin
                  bits[ch] = {bits[ch][30:0], sdata[ch]};
                  nrise[ch]++;
               end
               if (latch[ch] && !p_latch[ch]) begin
                  if (exp_q[ch].size() == 0) begin
                     check("unexpected_latch", ch, 32'd1, 32'd0);
                  end else begin
                     cur[ch] = exp_q[ch].pop_front();
                     check("serial_bits", ch, bits[ch], cur[ch].seq);
                     check("sclk_rises", ch, nrise[ch], cur[ch].nbits);
                     if (cur[ch].gap != 0)
                        check("latch_gap", ch, cyc - last_lat[ch], cur[ch].gap);
                  end
                  last_lat[ch] = cyc;
                  bits[ch] = '0; nrise[ch] = 0; lat_cnt[ch] = 0;
               end
               if (latch[ch]) lat_cnt[ch]++;
               if (!latch[ch] && p_latch[ch])
                  check("latch_width", ch, lat_cnt[ch], cur[ch].lat_cyc);
               if (busy[ch]) busy_cnt[ch]++;
               if (!busy[ch] && p_busy[ch]) begin
                  check("busy_cycles", ch, busy_cnt[ch], cur[ch].busy_cyc);
                  busy_cnt[ch] = 0;
               end
               p_sclk[ch] = sclk[ch]; p_latch[ch] = latch[ch]; p_busy[ch] = busy[ch];
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      valid = '0;
      arr_a = '0; arr_b = '0; arr_c = '0;
      repeat (3) @(negedge clk);
      for (int ch = 0; ch < 3; ch++)
         check("reset_outputs", ch, {sclk[ch], sdata[ch], latch[ch], ready[ch], busy[ch]}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_reset", 0, {29'd0, ready}, 32'h7);

      // msb-first 8'hA5: 1,0,1,0,0,1,0,1
      send(0, 32'hA5, 1'b0);
      push(0, 32'hA5, 8, 2, 34, 0);
      wait_drain();

      // lsb-first: A5 is a bit palindrome; 8'h01 gives 1 then seven 0s
      send(1, 32'hA5, 1'b0);
      push(1, 32'hA5, 8, 2, 34, 0);
      send(1, 32'h01, 1'b0);
      push(1, 32'h80, 8, 2, 34, 0);
      wait_drain();

      // Back-to-back with valid held; array switches to 8'h00 while FF is shifting
      send(0, 32'hFF, 1'b1);
      push(0, 32'hFF, 8, 2, 34, 0);
      send(0, 32'h00, 1'b0);
      push(0, 32'h00, 8, 2, 34, 35);
      wait_drain();

      // Reset ten cycles into a frame: no latch for the aborted frame
      send(0, 32'hC3, 1'b0);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midframe_reset_outputs", 0,
            {sclk[0], sdata[0], latch[0], ready[0], busy[0]}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send(0, 32'h3C, 1'b0);
      push(0, 32'h3C, 8, 2, 34, 0);
      wait_drain();

      // width 32, clk_div 1
      send(2, 32'h8000_0001, 1'b0);
      push(2, 32'h8000_0001, 32, 1, 65, 0);
      wait_drain();

      // Repeated array: dropped only when the skip feature is built in
      send(0, 32'h0F, 1'b0);
      push(0, 32'h0F, 8, 2, 34, 0);
      send(0, 32'h0F, 1'b0);
`ifdef INDICATOR_SHIFT_OUT_SKIP_UNCHANGED_EN
      check("dup_ready_busy", 0, {30'd0, ready[0], busy[0]}, 32'h2);
`else
      check("dup_ready_busy", 0, {30'd0, ready[0], busy[0]}, 32'h1);
      push(0, 32'h0F, 8, 2, 34, 0);
`endif
      send(0, 32'hF0, 1'b0);
      push(0, 32'hF0, 8, 2, 34, 0);
      wait_drain();

      for (int ch = 0; ch < 3; ch++)
         check("queue_drained", ch, exp_q[ch].size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
